// File: rtl/timebase_pkg.sv
// timebase_pkg: default parameters shared by the timebase generator and its stages.
package timebase_pkg;
    localparam int DEF_CNT_W    = 28;
    localparam int DEF_NORM_DIV = 100_000_000;
    localparam int DEF_TEST_DIV = 10;
    localparam int DEF_NUM_CH   = 3;
    localparam int DEF_CH_RATIO = 10;
endpackage

// File: rtl/timebase_gen_stage.sv
// tb_stage: one decade-style cascade stage, advancing on each wrap of the stage below.
import timebase_pkg::*;

module tb_stage #(
    parameter int RATIO = DEF_CH_RATIO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic wrap_o
);
    localparam int W = $clog2(RATIO);
    logic [W-1:0] cnt_q, cnt_d;
    assign wrap_o = inc_i & ~clr_i & (cnt_q == W'(RATIO - 1));
    always_comb cnt_d = (clr_i | wrap_o) ? '0 : inc_i ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/timebase_gen.sv
// timebase_gen: programmable base divider plus cascaded stages producing one-cycle tick enables.
import timebase_pkg::*;

module timebase_gen #(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int NORM_DIV = DEF_NORM_DIV,
    parameter int TEST_DIV = DEF_TEST_DIV,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CH_RATIO = DEF_CH_RATIO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              testmode,
    input  logic              period_we,
    input  logic [CNT_W-1:0]  period_i,
    output logic [NUM_CH-1:0] tick,
    output logic [CNT_W-1:0]  period_cur
);
    logic              tm_meta_q, tm_s_q, tm_prev_q, pend_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, act_q, sh_q, sh_d, per;
    logic              wr, pend_d, restart, apply;
    logic [NUM_CH-1:0] wrap, tick_q;

    assign per        = tm_s_q ? CNT_W'(TEST_DIV) : act_q;
    assign restart    = clr | (tm_s_q ^ tm_prev_q);
    assign wrap[0]    = en & ~restart & (cnt_q == per - CNT_W'(1));
    assign wr         = period_we & (period_i != '0);
    assign sh_d       = wr ? period_i : sh_q;
    assign pend_d     = wr | pend_q;
    assign apply      = restart | wrap[0];
    assign cnt_d      = (restart | wrap[0]) ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
    assign tick       = tick_q;
    assign period_cur = per;

    for (genvar k = 1; k < NUM_CH; k++) begin : g_stage
        tb_stage #(.RATIO(CH_RATIO)) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (restart),
            .inc_i (wrap[k-1]),
            .wrap_o(wrap[k])
        );
    end

    // A pending shadow period only takes effect at a period boundary or restart.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tm_meta_q <= 1'b0;
            tm_s_q    <= 1'b0;
            tm_prev_q <= 1'b0;
            cnt_q     <= '0;
            act_q     <= CNT_W'(NORM_DIV);
            sh_q      <= CNT_W'(NORM_DIV);
            pend_q    <= 1'b0;
            tick_q    <= '0;
        end else begin
            tm_meta_q <= testmode;
            tm_s_q    <= tm_meta_q;
            tm_prev_q <= tm_s_q;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            act_q     <= (apply & pend_d) ? sh_d : act_q;
            pend_q    <= pend_d & ~apply;
            tick_q    <= wrap;
        end
endmodule

// File: tb/tb_timebase_gen.sv
// tb_timebase_gen: randomized scoreboard bench with a wrap-count reference model.
module tb_timebase_gen;
    import timebase_pkg::*;
    localparam int CW = DEF_CNT_W;
    localparam int NC = DEF_NUM_CH;
    localparam int R  = DEF_CH_RATIO;
    localparam int TD = DEF_TEST_DIV;
    localparam int ND = DEF_NORM_DIV;

    logic clk = 0, rst_n = 0, en = 0, clr = 0, testmode = 0, period_we = 0;
    logic [CW-1:0] period_i = '0;
    logic [NC-1:0] tick;
    logic [CW-1:0] period_cur;

    always #5 clk = ~clk;

    timebase_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .testmode(testmode),
        .period_we(period_we), .period_i(period_i), .tick(tick), .period_cur(period_cur)
    );

    typedef struct {
        logic [NC-1:0] t;
        logic [CW-1:0] p;
    } exp_t;
    exp_t q[$];
    int n_chk = 0, n_pass = 0;

    bit m_s1, m_s2, m_prev, m_pend;
    int m_act, m_sh, m_phase, m_nwrap;

    task automatic check(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_prev = 0; m_pend = 0;
        m_act = ND; m_sh = ND; m_phase = 0; m_nwrap = 0;
    endfunction

    // Base ticks come from a phase count; channel k ticks on every R^k-th base wrap.
    function automatic exp_t model_step(bit e, bit c, bit tm, bit we, int pi);
        exp_t r;
        int per, nsh, div;
        bit restart, wrap, wr, npend;
        per     = m_s2 ? TD : m_act;
        restart = c || (m_s2 != m_prev);
        wrap    = !restart && e && (m_phase == per - 1);
        wr      = we && pi != 0;
        nsh     = wr ? pi : m_sh;
        npend   = m_pend || wr;
        if ((restart || wrap) && npend) begin
            m_act  = nsh;
            m_pend = 0;
        end else m_pend = npend;
        m_sh = nsh;
        r.t = '0;
        if (wrap) begin
            m_nwrap++;
            div = 1;
            for (int k = 0; k < NC; k++) begin
                r.t[k] = (m_nwrap % div) == 0;
                div *= R;
            end
        end
        m_phase = restart ? 0 : (e ? (wrap ? 0 : m_phase + 1) : m_phase);
        if (restart) m_nwrap = 0;
        m_prev = m_s2; m_s2 = m_s1; m_s1 = tm;
        r.p = CW'(m_s2 ? TD : m_act);
        return r;
    endfunction

    task automatic cyc(bit r, bit e, bit c, bit tm, bit we, int pi);
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e; clr = c; testmode = tm; period_we = we; period_i = CW'(pi);
        if (!r) begin
            model_reset();
            x.t = '0;
            x.p = CW'(ND);
        end else x = model_step(e, c, tm, we, pi);
        q.push_back(x);
    endtask

    initial forever begin
        exp_t x;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            check("tick", tick, x.t);
            check("period_cur", period_cur, x.p);
        end
    end

    initial begin
        bit tm, e, c, we;
        model_reset();
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        repeat (2100) cyc(1, 1, 0, 1, 0, 0);
        repeat (5) cyc(1, 1, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 1, 4);
        repeat (20) cyc(1, 1, 0, 1, 0, 0);
        repeat (40) cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0);
        repeat (12) cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 1);
        repeat (10) cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 7);
        repeat (20) cyc(1, 1, 0, 0, 0, 0);
        repeat (33) cyc(1, 1, 0, 1, 0, 0);
        repeat (30) cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        repeat (5) cyc(1, 1, 0, 0, 0, 0);
        repeat (7) cyc(1, 0, 0, 0, 0, 0);
        repeat (20) cyc(1, 1, 0, 0, 0, 0);
        repeat (4) cyc(1, 1, 1, 0, 0, 0);
        repeat (20) cyc(1, 1, 0, 0, 0, 0);
        tm = 0;
        repeat (1500) begin
            e  = $urandom_range(0, 9) != 0;
            c  = $urandom_range(0, 49) == 0;
            we = $urandom_range(0, 29) == 0;
            if ($urandom_range(0, 199) == 0) tm = ~tm;
            cyc(1, e, c, tm, we, int'($urandom_range(0, 12)));
        end
        cyc(1, 1, 0, 0, 1, 1);
        repeat (12) cyc(1, 1, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        check("async_rst_tick", tick, 0);
        check("async_rst_period", period_cur, ND);
        repeat (2) cyc(0, 1, 0, 1, 0, 0);
        repeat (40) cyc(1, 1, 0, 1, 0, 0);
        @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
